multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_types_pkg.sv | 51 +++++
 rtl/multicycle_ctrl_if.sv | 15 +
 rtl/mc_decode.sv | 28 ++
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types, encodings and RV32I opcodes for the multicycle controller
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALTED  = 3'd5
    } mc_state_t;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_IALU    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } inst_class_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_PC_IMM = 2'd1;
    localparam logic [1:0] PC_SEL_RS1    = 2'd2;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/data memory handshake bundle
interface multicycle_ctrl_if;
    import cpu_types_pkg::*;

    logic  ihit;
    logic  dhit;
    word_t inst;
    logic  iREN;
    logic  dREN;
    logic  dWEN;

    modport master (input ihit, input dhit, input inst, output iREN, output dREN, output dWEN);
    modport slave  (output ihit, output dhit, output inst, input iREN, input dREN, input dWEN);

endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode classification and immediate format selection
module mc_decode
    import cpu_types_pkg::*;
(
    input  logic [6:0]  i_opcode,
    output inst_class_t o_class,
    output imm_type_t   o_imm_type
);

    // Map the major opcode to an instruction class and immediate format
    always_comb begin
        o_class    = CLS_ILLEGAL;
        o_imm_type = IMM_R;
        case (i_opcode)
            OP_OP:     begin o_class = CLS_R;      o_imm_type = IMM_R; end
            OP_OP_IMM: begin o_class = CLS_IALU;   o_imm_type = IMM_I; end
            OP_LOAD:   begin o_class = CLS_LOAD;   o_imm_type = IMM_I; end
            OP_STORE:  begin o_class = CLS_STORE;  o_imm_type = IMM_S; end
            OP_BRANCH: begin o_class = CLS_BRANCH; o_imm_type = IMM_B; end
            OP_LUI:    begin o_class = CLS_LUI;    o_imm_type = IMM_U; end
            OP_AUIPC:  begin o_class = CLS_AUIPC;  o_imm_type = IMM_U; end
            OP_JAL:    begin o_class = CLS_JAL;    o_imm_type = IMM_J; end
            OP_JALR:   begin o_class = CLS_JALR;   o_imm_type = IMM_I; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM; MC_PERF_CNT_EN adds cycle/instret counters
module multicycle_ctrl
    import cpu_types_pkg::*;
#(
    parameter word_t HALT_INST = 32'hFFFFFFFF
) (
    input  logic               CLK,
    input  logic               RST,
    multicycle_ctrl_if.master  bus,
    input  logic               branch_taken,
    output logic               ir_load,
    output logic               pc_en,
    output logic [1:0]         pc_sel,
    output logic               rf_wen,
    output logic               alu_src_imm,
    output imm_type_t          imm_type,
    output logic               halt,
    output logic               illegal
`ifdef MC_PERF_CNT_EN
    ,
    output word_t              cycle_cnt,
    output word_t              instret_cnt
`endif
);

    mc_state_t   r_state;
    mc_state_t   w_state_next;
    word_t       r_ir;
    inst_class_t w_class;
    imm_type_t   w_dec_imm;
    logic        w_uses_imm;

    logic        w_iren;
    logic        w_dren;
    logic        w_dwen;
    logic        w_ir_load;
    logic        w_pc_en;
    logic [1:0]  w_pc_sel;
    logic        w_rf_wen;
    logic        w_alu_src_imm;
    imm_type_t   w_imm_type;
    logic        w_halt;
    logic        w_illegal;

    mc_decode u_decode (
        .i_opcode   (r_ir[6:0]),
        .o_class    (w_class),
        .o_imm_type (w_dec_imm)
    );

    // R-type and branches compare/combine two registers; everything else takes the immediate
    assign w_uses_imm = (w_class != CLS_R) && (w_class != CLS_BRANCH);

    // State register; reset abandons any in-flight access and restarts at FETCH
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction register, captured only on the fetch handshake
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= bus.inst;
        end
    end

    // Next-state and control decode from state and the latched instruction
    always_comb begin
        w_state_next  = r_state;
        w_iren        = 1'b0;
        w_dren        = 1'b0;
        w_dwen        = 1'b0;
        w_ir_load     = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_sel      = PC_SEL_PLUS4;
        w_rf_wen      = 1'b0;
        w_alu_src_imm = 1'b0;
        w_imm_type    = IMM_R;
        w_halt        = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_iren = 1'b1;
                if (bus.ihit) begin
                    w_ir_load    = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_imm_type   = w_dec_imm;
                w_state_next = (r_ir == HALT_INST) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                w_imm_type    = w_dec_imm;
                w_alu_src_imm = w_uses_imm;
                case (w_class)
                    CLS_BRANCH: begin
                        w_pc_en      = 1'b1;
                        w_pc_sel     = branch_taken ? PC_SEL_PC_IMM : PC_SEL_PLUS4;
                        w_state_next = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_state_next = ST_MEM;
                    end
                    CLS_ILLEGAL: begin
                        w_illegal    = 1'b1;
                        w_pc_en      = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                    default: begin
                        w_state_next = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                w_imm_type    = w_dec_imm;
                w_alu_src_imm = w_uses_imm;
                w_dren        = (w_class == CLS_LOAD);
                w_dwen        = (w_class == CLS_STORE);
                if (bus.dhit) begin
                    if (w_class == CLS_LOAD) begin
                        w_state_next = ST_WB;
                    end else begin
                        w_pc_en      = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                w_imm_type    = w_dec_imm;
                w_alu_src_imm = w_uses_imm;
                w_rf_wen      = 1'b1;
                w_pc_en       = 1'b1;
                if (w_class == CLS_JAL) begin
                    w_pc_sel = PC_SEL_PC_IMM;
                end else if (w_class == CLS_JALR) begin
                    w_pc_sel = PC_SEL_RS1;
                end
                w_state_next = ST_FETCH;
            end
            ST_HALTED: begin
                w_halt = 1'b1;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Fetch-side strobes stay quiet while reset is held even though the state already reads FETCH
    assign bus.iREN    = w_iren & ~RST;
    assign ir_load     = w_ir_load & ~RST;
    assign bus.dREN    = w_dren;
    assign bus.dWEN    = w_dwen;
    assign pc_en       = w_pc_en;
    assign pc_sel      = w_pc_sel;
    assign rf_wen      = w_rf_wen;
    assign alu_src_imm = w_alu_src_imm;
    assign imm_type    = w_imm_type;
    assign halt        = w_halt;
    assign illegal     = w_illegal;

`ifdef MC_PERF_CNT_EN
    word_t r_cycle_cnt;
    word_t r_instret_cnt;

    // Free-running cycle count (frozen once halted) and retired-instruction count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != ST_HALTED) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_pc_en) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam logic [31:0] HALT_WORD = 32'hFFFFFFFF;

    typedef struct {
        int lat;
        int rf;
        int pcn;
        int psel;
        int imm;
        int ill;
        int dr;
        int dw;
        int alu;
        int loads;
        int cf;
        int imm_var;
        int halted;
        int to;
    } res_t;

    typedef struct {
        logic [31:0] ins;
        bit          bt;
        int          id;
        int          dd;
        res_t        e;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        branch_taken;
    logic        ir_load;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        rf_wen;
    logic        alu_src_imm;
    logic [2:0]  imm_type;
    logic        halt;
    logic        illegal;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vq[$];
    logic [6:0] legal_ops [9];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.HALT_INST(HALT_WORD)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus),
        .branch_taken (branch_taken),
        .ir_load      (ir_load),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .rf_wen       (rf_wen),
        .alu_src_imm  (alu_src_imm),
        .imm_type     (imm_type),
        .halt         (halt),
        .illegal      (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.iREN, bus.dREN, bus.dWEN, ir_load, pc_en, pc_sel,
                     rf_wen, alu_src_imm, imm_type, halt, illegal});
    endfunction

    function automatic res_t mkr(int lat, int rf, int psel, int imm, int ill, int dr, int dw, int alu);
        res_t r;
        r.lat = lat; r.rf = rf; r.pcn = 1; r.psel = psel; r.imm = imm; r.ill = ill;
        r.dr = dr; r.dw = dw; r.alu = alu; r.loads = 1; r.cf = 0; r.imm_var = 0;
        r.halted = 0; r.to = 0;
        return r;
    endfunction

    // Instruction-level reference: latency and per-instruction effects from the class rules
    function automatic res_t model(logic [31:0] ins, bit bt, int dd);
        res_t r;
        r = mkr(4, 1, 0, 1, 0, 0, 0, 1);
        case (ins[6:0])
            7'b0110011: begin r.imm = 0; r.alu = 0; end
            7'b0010011: r.imm = 1;
            7'b0000011: begin r.imm = 1; r.lat = 5 + dd; r.dr = dd + 1; end
            7'b0100011: begin r.imm = 2; r.lat = 4 + dd; r.rf = 0; r.dw = dd + 1; end
            7'b1100011: begin r.imm = 3; r.lat = 3; r.rf = 0; r.alu = 0; r.psel = bt ? 1 : 0; end
            7'b0110111, 7'b0010111: r.imm = 4;
            7'b1101111: begin r.imm = 5; r.psel = 1; end
            7'b1100111: begin r.imm = 1; r.psel = 2; end
            default: begin r.imm = 0; r.lat = 3; r.rf = 0; r.ill = 1; end
        endcase
        return r;
    endfunction

    // Drive one instruction through fetch/memory handshakes and tally what the DUT does
    task automatic run_instr(input logic [31:0] ins, input bit bt, input int id, input int dd, output res_t o);
        int fetch_n = 0;
        int mem_n   = 0;
        int idx     = -1;
        bit done    = 1'b0;
        o = mkr(0, 0, 0, 0, 0, 0, 0, 0);
        o.pcn = 0;
        o.loads = 0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge CLK);
            branch_taken = bt;
            if (bus.iREN && idx >= 0) begin
                bus.ihit = 1'b0;
                bus.dhit = 1'b0;
                done = 1'b1;
            end else begin
                if (bus.iREN) begin
                    bus.ihit = (fetch_n == id);
                    bus.inst = ins;
                    fetch_n++;
                end else begin
                    bus.ihit = 1'($urandom_range(0, 1));
                    bus.inst = $urandom;
                end
                if (bus.dREN || bus.dWEN) begin
                    bus.dhit = (mem_n == dd);
                    mem_n++;
                end else begin
                    bus.dhit = 1'($urandom_range(0, 1));
                end
                #1;
                if (bus.iREN && (bus.dREN || bus.dWEN)) o.cf++;
                if (ir_load) o.loads++;
                if (idx < 0 && ir_load) idx = 0;
                else if (idx >= 0) idx++;
                if (idx >= 0) begin
                    o.lat = idx + 1;
                    if (idx == 1) o.imm = int'(imm_type);
                    if (idx >= 1 && !halt && int'(imm_type) != o.imm) o.imm_var++;
                    if (idx == 2) o.alu = int'(alu_src_imm);
                    if (halt) begin
                        if (o.halted == 0) o.halted = idx;
                        done = 1'b1;
                    end
                end
                if (pc_en) begin
                    o.pcn++;
                    o.psel = int'(pc_sel);
                end
                if (rf_wen)   o.rf++;
                if (illegal)  o.ill++;
                if (bus.dREN) o.dr++;
                if (bus.dWEN) o.dw++;
            end
        end
        if (!done) o.to = 1;
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t e);
        chk({tag, ".lat"},     a.lat,     e.lat);
        chk({tag, ".rf_wen"},  a.rf,      e.rf);
        chk({tag, ".pc_en"},   a.pcn,     e.pcn);
        chk({tag, ".pc_sel"},  a.psel,    e.psel);
        chk({tag, ".imm"},     a.imm,     e.imm);
        chk({tag, ".illegal"}, a.ill,     e.ill);
        chk({tag, ".dREN"},    a.dr,      e.dr);
        chk({tag, ".dWEN"},    a.dw,      e.dw);
        chk({tag, ".alu_imm"}, a.alu,     e.alu);
        chk({tag, ".ir_load"}, a.loads,   e.loads);
        chk({tag, ".req_mix"}, a.cf,      e.cf);
        chk({tag, ".imm_var"}, a.imm_var, e.imm_var);
        chk({tag, ".halted"},  a.halted,  e.halted);
        chk({tag, ".timeout"}, a.to,      e.to);
    endtask

    task automatic add_vec(input logic [31:0] ins, input bit bt, input int id, input int dd, input res_t e);
        vec_t v;
        v.ins = ins; v.bt = bt; v.id = id; v.dd = dd; v.e = e;
        vq.push_back(v);
    endtask

    // Park a store in MEM, then pulse reset between clock edges
    task automatic reset_mid_mem();
        bit seen = 1'b0;
        bit fetched = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            bus.dhit = 1'b0;
            if (bus.iREN && !fetched) begin
                bus.ihit = 1'b1;
                bus.inst = 32'h00112023;
                fetched = 1'b1;
            end else begin
                bus.ihit = 1'b0;
            end
            #1;
            if (bus.dWEN) seen = 1'b1;
        end
        chk("mem_dwen_seen", int'(seen), 1);
        #1;
        RST = 1'b1;
        bus.ihit = 1'b1;
        #1;
        chk("rst_mid_mem_dwen", int'(bus.dWEN), 0);
        chk("rst_mid_mem_outs", outs(), 0);
`ifdef MC_PERF_CNT_EN
        chk("rst_cycle_cnt", int'(cycle_cnt), 0);
        chk("rst_instret_cnt", int'(instret_cnt), 0);
`endif
        @(negedge CLK);
        #1;
        chk("rst_held_outs", outs(), 0);
        RST = 1'b0;
        bus.ihit = 1'b0;
        #1;
        chk("rst_release_iren", int'(bus.iREN), 1);
    endtask

    initial begin
        res_t r;
        logic [31:0] ins;
        bit bt;
        int id;
        int dd;
        int badh;

        legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
        legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b0110111;
        legal_ops[6] = 7'b0010111; legal_ops[7] = 7'b1101111; legal_ops[8] = 7'b1100111;

        add_vec(32'h00500093, 1'b0, 0, 0, mkr(4, 1, 0, 1, 0, 0, 0, 1));
        add_vec(32'h003100b3, 1'b0, 0, 0, mkr(4, 1, 0, 0, 0, 0, 0, 0));
        add_vec(32'h00012083, 1'b0, 0, 2, mkr(7, 1, 0, 1, 0, 3, 0, 1));
        add_vec(32'h00112023, 1'b0, 0, 0, mkr(4, 0, 0, 2, 0, 0, 1, 1));
        add_vec(32'h00000463, 1'b1, 0, 0, mkr(3, 0, 1, 3, 0, 0, 0, 0));
        add_vec(32'h00000463, 1'b0, 0, 0, mkr(3, 0, 0, 3, 0, 0, 0, 0));
        add_vec(32'h000010b7, 1'b0, 0, 0, mkr(4, 1, 0, 4, 0, 0, 0, 1));
        add_vec(32'h00001097, 1'b0, 0, 0, mkr(4, 1, 0, 4, 0, 0, 0, 1));
        add_vec(32'h008000ef, 1'b0, 0, 0, mkr(4, 1, 1, 5, 0, 0, 0, 1));
        add_vec(32'h000100e7, 1'b0, 0, 0, mkr(4, 1, 2, 1, 0, 0, 0, 1));
        add_vec(32'h0000007f, 1'b0, 0, 0, mkr(3, 0, 0, 0, 1, 0, 0, 1));
        add_vec(32'h00112023, 1'b0, 2, 3, mkr(7, 0, 0, 2, 0, 0, 4, 1));
        add_vec(32'h00012083, 1'b0, 1, 0, mkr(5, 1, 0, 1, 0, 1, 0, 1));

        RST = 1'b1;
        branch_taken = 1'b0;
        bus.ihit = 1'b1;
        bus.dhit = 1'b1;
        bus.inst = 32'h00500093;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_outs", outs(), 0);
`ifdef MC_PERF_CNT_EN
        chk("reset_cycle_cnt", int'(cycle_cnt), 0);
        chk("reset_instret_cnt", int'(instret_cnt), 0);
`endif
        RST = 1'b0;
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        #1;
        chk("reset_release_iren", int'(bus.iREN), 1);

        foreach (vq[i]) begin
            run_instr(vq[i].ins, vq[i].bt, vq[i].id, vq[i].dd, r);
            cmp_res($sformatf("vec%0d", i), r, vq[i].e);
        end

        for (int i = 0; i < 150; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = legal_ops[$urandom_range(0, 8)];
            if (ins == HALT_WORD) ins[31] = 1'b0;
            bt = 1'($urandom_range(0, 1));
            id = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            run_instr(ins, bt, id, dd, r);
            cmp_res($sformatf("rnd%0d_%08h", i, ins), r, model(ins, bt, dd));
        end

        reset_mid_mem();
        run_instr(32'h00500093, 1'b0, 0, 0, r);
        cmp_res("post_rst_addi", r, model(32'h00500093, 1'b0, 0));
`ifdef MC_PERF_CNT_EN
        chk("post_rst_instret", int'(instret_cnt), 1);
        chk("post_rst_cycle_nonzero", int'(cycle_cnt != 0), 1);
`endif

        run_instr(HALT_WORD, 1'b0, 0, 0, r);
        chk("halt.halted_at", r.halted, 2);
        chk("halt.ir_load", r.loads, 1);
        chk("halt.pc_en", r.pcn, 0);
        chk("halt.rf_wen", r.rf, 0);
        chk("halt.illegal", r.ill, 0);
        chk("halt.timeout", r.to, 0);
        badh = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            bus.ihit = 1'($urandom_range(0, 1));
            bus.dhit = 1'($urandom_range(0, 1));
            bus.inst = $urandom;
            branch_taken = 1'($urandom_range(0, 1));
            #1;
            if (outs() != 2) badh++;
        end
        chk("halt_hold_bad_cycles", badh, 0);

        @(negedge CLK);
        RST = 1'b1;
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        run_instr(32'h0000007f, 1'b0, 0, 0, r);
        cmp_res("post_halt_illegal", r, model(32'h0000007f, 1'b0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
